cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 171 +++++++++++++++++
 tb/tb_cache_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller
//  Description : Two-way set-associative, write-through / no-write-allocate
//                data cache sitting between a pipeline memory stage and a
//                downstream SRAM controller. One 32-bit word per line,
//                64 sets, one LRU bit per set.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1  clock, all state updates on rising edge
//    rst           in   1  synchronous reset, active low
//    wrEn, rdEn    in   1  store / load request from the memory stage
//    address       in  32  byte address
//    writeData     in  32  store data
//    readData      out 32  load result (0 when no load completes)
//    ready         out  1  low freezes the pipeline
//    sramWrEn      out  1  write request to SRAM controller
//    sramRdEn      out  1  read request to SRAM controller
//    sramAddress   out 32  forwarded byte address
//    sramWriteData out 32  forwarded store data
//    sramReadData  in  32  word returned by SRAM controller
//    sramReady     in   1  SRAM completion pulse
// ============================================================================
module cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn,
    input  logic        rdEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        sramWrEn,
    output logic        sramRdEn,
    output logic [31:0] sramAddress,
    output logic [31:0] sramWriteData,
    input  logic [31:0] sramReadData,
    input  logic        sramReady
);

    localparam int unsigned c_NUM_SETS = 64;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_MISS = 2'd1;
    localparam logic [1:0] c_WR_THRU = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_cur_state;
    logic [1:0]  w_next_state;

    logic [31:0] r_data  [2][c_NUM_SETS];
    logic [10:0] r_tag   [2][c_NUM_SETS];
    logic [63:0] r_valid [2];
    logic [63:0] r_lru;

    logic [16:0] w_word_addr;
    logic [5:0]  w_set;
    logic [10:0] w_tag;
    logic        w_hit0;
    logic        w_hit1;
    logic        w_hit;
    logic        w_hit_way;
    logic [31:0] w_hit_data;
    logic        w_victim;
    logic        w_read_hit;
    logic        w_fill;
    logic        w_wr_update;

    // The cached region starts at byte 1024; only 17 word-address bits
    // (6 set + 11 tag) are meaningful.
    assign w_word_addr = 17'((address - 32'd1024) >> 2);
    assign w_set       = w_word_addr[5:0];
    assign w_tag       = w_word_addr[16:6];

    assign w_hit0     = r_valid[0][w_set] && (r_tag[0][w_set] == w_tag);
    assign w_hit1     = r_valid[1][w_set] && (r_tag[1][w_set] == w_tag);
    assign w_hit      = w_hit0 || w_hit1;
    assign w_hit_way  = w_hit1;
    assign w_hit_data = w_hit1 ? r_data[1][w_set] : r_data[0][w_set];

    // Invalid ways are filled in order before LRU replacement kicks in.
    assign w_victim = !r_valid[0][w_set] ? 1'b0 :
                      !r_valid[1][w_set] ? 1'b1 : r_lru[w_set];

    assign sramAddress   = address;
    assign sramWriteData = writeData;

    // While reset is held the outputs behave as IDLE so an in-flight SRAM
    // request is withdrawn immediately rather than lingering for a cycle.
    assign w_cur_state = rst ? r_state : c_IDLE;

    always_comb begin
        w_next_state = w_cur_state;
        ready        = 1'b1;
        readData     = 32'd0;
        sramRdEn     = 1'b0;
        sramWrEn     = 1'b0;
        w_read_hit   = 1'b0;
        case (w_cur_state)
            c_IDLE: begin
                if (wrEn) begin
                    w_next_state = c_WR_THRU;
                    ready        = 1'b0;
                end else if (rdEn) begin
                    if (w_hit) begin
                        readData   = w_hit_data;
                        w_read_hit = 1'b1;
                    end else begin
                        w_next_state = c_RD_MISS;
                        ready        = 1'b0;
                    end
                end
            end
            c_RD_MISS: begin
                sramRdEn = 1'b1;
                ready    = sramReady;
                if (sramReady) begin
                    readData     = sramReadData;
                    w_next_state = c_IDLE;
                end
            end
            c_WR_THRU: begin
                sramWrEn = 1'b1;
                ready    = sramReady;
                if (sramReady) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Address is held stable by the pipeline, so the hit computed at the
    // completion edge is the same one seen when the write was accepted.
    assign w_fill      = (w_cur_state == c_RD_MISS) && sramReady;
    assign w_wr_update = (w_cur_state == c_WR_THRU) && sramReady && w_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_lru      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_read_hit || w_wr_update) begin
                r_lru[w_set] <= ~w_hit_way;
            end
            if (w_fill) begin
                r_valid[w_victim][w_set] <= 1'b1;
                r_lru[w_set]             <= ~w_victim;
            end
        end
    end

    // Line payload needs no reset; validity alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_victim][w_set] <= sramReadData;
            r_tag[w_victim][w_set]  <= w_tag;
        end
        if (w_wr_update) begin
            r_data[w_hit_way][w_set] <= writeData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_controller
//  Description : Scoreboard bench for cache_controller. A driver issues
//                directed then random loads/stores, a reference model
//                (per-set MRU list + flat memory) predicts hit/miss and data,
//                a behavioural SRAM answers requests with random latency and
//                a monitor compares each completed transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wrEn = 1'b0;
    logic        rdEn = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] writeData = 32'd0;
    logic [31:0] readData;
    logic        ready;
    logic        sramWrEn;
    logic        sramRdEn;
    logic [31:0] sramAddress;
    logic [31:0] sramWriteData;
    logic [31:0] sramReadData = 32'd0;
    logic        sramReady = 1'b0;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .wrEn         (wrEn),
        .rdEn         (rdEn),
        .address      (address),
        .writeData    (writeData),
        .readData     (readData),
        .ready        (ready),
        .sramWrEn     (sramWrEn),
        .sramRdEn     (sramRdEn),
        .sramAddress  (sramAddress),
        .sramWriteData(sramWriteData),
        .sramReadData (sramReadData),
        .sramReady    (sramReady)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // ---------------- behavioural SRAM ----------------
    logic [31:0] sram_mem [logic [31:0]];
    int          min_lat = 0;

    function automatic logic [31:0] sram_rd(input logic [31:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return init_val(a);
    endfunction

    initial begin
        bit busy = 1'b0;
        int lat  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (sramReady) begin
                sramReady    = 1'b0;
                sramReadData = 32'd0;
                busy         = 1'b0;
            end else if (rst && (sramRdEn || sramWrEn)) begin
                if (!busy) begin
                    busy = 1'b1;
                    lat  = $urandom_range(min_lat, min_lat + 3);
                end
                if (lat == 0) begin
                    check("sram_addr", sramAddress, address);
                    if (sramWrEn) begin
                        check("sram_wdata", sramWriteData, writeData);
                        sram_mem[sramAddress] = sramWriteData;
                    end else begin
                        sramReadData = sram_rd(sramAddress);
                    end
                    sramReady = 1'b1;
                end else begin
                    lat--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    int unsigned  lst [64][$];          // resident tags per set, MRU first
    logic [31:0]  ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) lst[s].delete();
    endfunction

    function automatic bit model_access(input logic [31:0] a, input bit is_wr, input logic [31:0] d);
        logic [31:0] w;
        int          s;
        int unsigned t;
        int          idx;
        w   = (a - 32'd1024) >> 2;
        s   = int'(w[5:0]);
        t   = int'(w[16:6]);
        idx = -1;
        foreach (lst[s][i]) if (lst[s][i] == t) idx = i;
        if (is_wr) ref_mem[a] = d;
        if (idx >= 0) begin
            lst[s].delete(idx);
            lst[s].push_front(t);
            return 1'b1;
        end
        if (!is_wr) begin
            lst[s].push_front(t);
            if (lst[s].size() > 2) void'(lst[s].pop_back());
        end
        return 1'b0;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_rd;
        bit          hit;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;
    exp_t sbq [$];

    initial begin
        int   cyc    = 0;
        bit   saw_rd = 1'b0;
        bit   saw_wr = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cyc = 0; saw_rd = 1'b0; saw_wr = 1'b0;
            end else if (rdEn || wrEn) begin
                cyc++;
                if (sramRdEn) saw_rd = 1'b1;
                if (sramWrEn) saw_wr = 1'b1;
                if (ready) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_empty: got unexpected completion expected none at %0t", $time);
                    end else begin
                        e = sbq.pop_front();
                        if (e.is_rd) begin
                            check($sformatf("rd_hit@%h", e.addr),
                                  {31'd0, (cyc == 1) && !saw_rd}, {31'd0, e.hit});
                            check($sformatf("rd_data@%h", e.addr), readData, e.data);
                        end else begin
                            check($sformatf("wr_thru@%h", e.addr),
                                  {30'd0, saw_rd, saw_wr}, 32'd1);
                            check($sformatf("wr_rdata@%h", e.addr), readData, 32'd0);
                        end
                    end
                    cyc = 0; saw_rd = 1'b0; saw_wr = 1'b0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        e.addr  = a;
        e.is_rd = rd && !wr;
        if (wr) begin
            e.hit  = model_access(a, 1'b1, d);
            e.data = 32'd0;
        end else begin
            e.hit  = model_access(a, 1'b0, 32'd0);
            e.data = ref_rd(a);
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        wrEn = wr; rdEn = rd; address = a; writeData = d;
        n = 0;
        @(negedge clk);
        while (!ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!ready) begin
            checks++; failures++;
            $display("FAIL timeout@%h: got ready=0 expected ready=1 within 60 cycles", a);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            wrEn = 1'b0; rdEn = 1'b0;
        end
    endtask

    function automatic logic [31:0] mk_addr(input int set, input int tag);
        return 32'd1024 + 32'((tag * 64 + set) * 4);
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        // reset held: outputs idle-like
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",    {31'd0, ready},    32'd1);
        check("rst_sramRdEn", {31'd0, sramRdEn}, 32'd0);
        check("rst_sramWrEn", {31'd0, sramWrEn}, 32'd0);
        check("rst_readData", readData,          32'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready",    {31'd0, ready},    32'd1);
        check("post_rst_sramRdEn", {31'd0, sramRdEn}, 32'd0);
        check("post_rst_readData", readData,          32'd0);

        sram_mem[32'h400] = 32'h1234_5678;
        ref_mem[32'h400]  = 32'h1234_5678;

        // cold read, re-read, conflict eviction
        do_op(1'b0, 1'b1, 32'h400, 32'd0);
        do_op(1'b0, 1'b1, 32'h400, 32'd0);
        do_op(1'b0, 1'b1, 32'h500, 32'd0);
        do_op(1'b0, 1'b1, 32'h600, 32'd0);
        do_op(1'b0, 1'b1, 32'h500, 32'd0);
        do_op(1'b0, 1'b1, 32'h400, 32'd0);
        idle(1);
        // write hit / write miss
        do_op(1'b1, 1'b0, 32'h400, 32'hDEAD_BEEF);
        do_op(1'b0, 1'b1, 32'h400, 32'd0);
        do_op(1'b1, 1'b0, 32'h800, 32'h0BAD_F00D);
        do_op(1'b0, 1'b1, 32'h800, 32'd0);
        // simultaneous requests: store wins
        do_op(1'b1, 1'b1, 32'h800, 32'hCAFE_F00D);
        do_op(1'b0, 1'b1, 32'h800, 32'd0);
        idle(2);

        // reset in the middle of a read miss
        min_lat = 4;
        @(posedge clk); #1;
        rdEn = 1'b1; address = 32'h900;
        n = 0;
        @(negedge clk);
        while (!sramRdEn && n < 10) begin n++; @(negedge clk); end
        check("abort_sramRdEn_seen", {31'd0, sramRdEn}, 32'd1);
        @(posedge clk); #1; rst = 1'b0; rdEn = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("abort_sramRdEn", {31'd0, sramRdEn}, 32'd0);
        check("abort_ready",    {31'd0, ready},    32'd1);
        min_lat = 0;
        do_op(1'b0, 1'b1, 32'h900, 32'd0);
        do_op(1'b0, 1'b1, 32'h400, 32'd0);
        idle(1);

        // randomized traffic on a few sets to force conflicts
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int          r;
            a = mk_addr($urandom_range(0, 3), $urandom_range(0, 5));
            r = $urandom_range(0, 9);
            if (r < 6)      do_op(1'b0, 1'b1, a, 32'd0);
            else if (r < 9) do_op(1'b1, 1'b0, a, $urandom);
            else            do_op(1'b1, 1'b1, a, $urandom);
            idle($urandom_range(0, 2));
        end
        idle(4);
        check("sb_drained", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
